// File: rtl/case7_lane_pipe.sv
// Two-stage valid/ready pipeline evaluating the case7 {y1,y2,y3} function on LANES 6-bit operands.
// Optional per-output statistics counters are enabled by defining CASE7_LANE_STATS_EN.
module case7_lane_pipe #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3*LANES-1:0]   out_data,
  input  logic                 stat_clr,
  output logic [CNT_W-1:0]     cnt_y1,
  output logic [CNT_W-1:0]     cnt_y2,
  output logic [CNT_W-1:0]     cnt_y3
);

  function automatic logic [2:0] lane_fn(input logic [5:0] x);
    logic a, b, c, d, e, f, cd;
    {a, b, c, d, e, f} = x;
    cd = c & d;
    lane_fn[2] = (a | b | cd) & (e | (~cd & ~f));
    lane_fn[1] = a | b | f;
    lane_fn[0] = ((~e | ~f) & (a | b | f)) | cd;
  endfunction

  logic                v1, v2;
  logic [6*LANES-1:0]  d1;
  logic [3*LANES-1:0]  r2;
  logic [3*LANES-1:0]  res;
  logic                s1_load, s2_load;

  assign s2_load   = !v2 || out_ready;
  assign s1_load   = !v1 || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = v2;
  assign out_data  = r2;

  always_comb begin
    res = '0;
    for (int k = 0; k < LANES; k++) begin
      res[3*k +: 3] = lane_fn(d1[6*k +: 6]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      r2 <= '0;
    end else begin
      if (s1_load) v1 <= in_valid;
      if (s2_load) v2 <= v1;
      // Result register only moves on real words so it stays quiet across bubbles.
      if (s2_load && v1) r2 <= res;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load && in_valid) d1 <= in_data;
  end

`ifdef CASE7_LANE_STATS_EN
  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + PC_W;

  function automatic logic [PC_W-1:0] pop(input logic [3*LANES-1:0] r, input int bitpos);
    pop = '0;
    for (int k = 0; k < LANES; k++) begin
      pop = pop + PC_W'(r[3*k + bitpos]);
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [PC_W-1:0] inc);
    logic [SUM_W-1:0] s;
    logic [SUM_W-1:0] top;
    s   = SUM_W'(c) + SUM_W'(inc);
    top = SUM_W'({CNT_W{1'b1}});
    sat_add = (s > top) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic out_xfer;
  assign out_xfer = v2 && out_ready;

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      cnt_y1 <= '0;
      cnt_y2 <= '0;
      cnt_y3 <= '0;
    end else if (out_xfer) begin
      cnt_y1 <= sat_add(cnt_y1, pop(r2, 2));
      cnt_y2 <= sat_add(cnt_y2, pop(r2, 1));
      cnt_y3 <= sat_add(cnt_y3, pop(r2, 0));
    end
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign cnt_y1 = '0;
  assign cnt_y2 = '0;
  assign cnt_y3 = '0;
`endif

endmodule

// File: tb/tb_case7_lane_pipe.sv
// Directed bench for case7_lane_pipe (LANES=2, CNT_W=4) with a queue-based reference model.
module tb_case7_lane_pipe;
  localparam int L  = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, stat_clr;
  logic [6*L-1:0] in_data;
  logic [3*L-1:0] out_data;
  logic [CW-1:0]  cnt_y1, cnt_y2, cnt_y3;

  case7_lane_pipe #(.LANES(L), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stat_clr(stat_clr), .cnt_y1(cnt_y1), .cnt_y2(cnt_y2), .cnt_y3(cnt_y3)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_fn(input logic [5:0] x);
    logic a, b, c, d, e, f, cd;
    {a, b, c, d, e, f} = x;
    cd = c & d;
    return {(a | b | cd) & (e | (~cd & ~f)), a | b | f, ((~e | ~f) & (a | b | f)) | cd};
  endfunction

  function automatic logic [3*L-1:0] ref_word(input logic [6*L-1:0] w);
    logic [3*L-1:0] r;
    for (int k = 0; k < L; k++) r[3*k +: 3] = ref_fn(w[6*k +: 6]);
    return r;
  endfunction

  // Reference model: words in flight with their accept cycle, plus counters.
  logic [3*L-1:0] exp_q[$];
  int             acc_q[$];
  int             cyc = 0;
  int             m_cnt[3] = '{0, 0, 0};
  bit             model_on = 0;

  always @(negedge clk) begin
    logic ev, er, ix, ox;
    logic [3*L-1:0] w;
    ev = (exp_q.size() > 0) && (cyc - acc_q[0] >= 2);
    er = (exp_q.size() < 2) || out_ready;
    if (model_on) begin
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, er);
      if (ev) chk("out_data", out_data, exp_q[0]);
`ifdef CASE7_LANE_STATS_EN
      chk("cnt_y1", cnt_y1, m_cnt[0]);
      chk("cnt_y2", cnt_y2, m_cnt[1]);
      chk("cnt_y3", cnt_y3, m_cnt[2]);
`else
      chk("cnt_y1_tied", cnt_y1, 0);
      chk("cnt_y2_tied", cnt_y2, 0);
      chk("cnt_y3_tied", cnt_y3, 0);
`endif
    end
    ix = in_valid && er;
    ox = ev && out_ready;
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      m_cnt = '{0, 0, 0};
      model_on = 1;
    end else begin
      if (ox) begin
        w = exp_q.pop_front();
        void'(acc_q.pop_front());
        for (int k = 0; k < L; k++)
          for (int j = 0; j < 3; j++)
            if (w[3*k + 2 - j]) m_cnt[j] = (m_cnt[j] >= (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt[j] + 1;
      end
      if (stat_clr) m_cnt = '{0, 0, 0};
      if (ix) begin
        exp_q.push_back(ref_word(in_data));
        acc_q.push_back(cyc);
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [6*L-1:0] bp_w[3];
  int idx, em, ones;
  bit acc;

  initial begin
    rst = 1; in_valid = 0; out_ready = 1; stat_clr = 0; in_data = '0;
    step(); step();
    rst = 0;

    // Reset state, first cycle after deassertion
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_cnt_y2", cnt_y2, 0);
    step();

    // Pin the reference function
    chk("fn_zero", ref_fn(6'b000000), 3'b000);
    chk("fn_aef", ref_fn(6'b100011), 3'b110);
    chk("fn_cd", ref_fn(6'b001100), 3'b001);
    chk("fn_a", ref_fn(6'b100000), 3'b111);
    chk("word_320", ref_word(12'h320), 6'h0F);

    // Latency: accept in cycle 0, out_valid in cycle 2
    in_valid = 1; in_data = 12'h320;
    step();
    in_valid = 0; in_data = '0;
    @(negedge clk);
    chk("lat_c1_valid", out_valid, 0);
    step();
    @(negedge clk);
    chk("lat_c2_valid", out_valid, 1);
    chk("lat_c2_data", out_data, 6'h0F);
    step();
`ifdef CASE7_LANE_STATS_EN
    @(negedge clk);
    chk("first_cnt_y1", cnt_y1, 1);
    chk("first_cnt_y2", cnt_y2, 1);
    chk("first_cnt_y3", cnt_y3, 2);
`endif

    // Exhaustive sweep through lane 0 and lane L-1
    for (int i = 0; i < 64; i++) begin
      in_valid = 1;
      in_data = {6'(i) ^ 6'h2A, 6'(i)};
      step();
    end
    in_valid = 0;
    step(); step(); step();

    // Backpressure: three words offered with out_ready low
    bp_w[0] = 12'h123; bp_w[1] = 12'h456; bp_w[2] = 12'h789;
    out_ready = 0; idx = 0;
    for (int t = 0; t < 6; t++) begin
      in_valid = (idx < 3);
      in_data = bp_w[idx < 3 ? idx : 2];
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 2);
    out_ready = 1;
    for (int t = 0; t < 10 && idx < 3; t++) begin
      in_valid = 1; in_data = bp_w[2];
      @(negedge clk);
      acc = in_ready;
      step();
      if (acc) idx++;
    end
    chk("bp_third", idx, 3);
    in_valid = 0;
    step(); step(); step();

    // Alternating out_ready with continuous in_valid
    idx = 0; em = 0; ones = 0;
    in_valid = 1;
    for (int t = 0; t < 40; t++) begin
      out_ready = t[0];
      in_data = 12'(idx * 97 + 5);
      @(negedge clk);
      acc = in_ready;
      if (t >= 4) begin
        if (out_valid && out_ready) em++;
        if (out_ready) ones++;
      end
      step();
      if (acc) idx++;
    end
    chk("duty_throughput", em, ones);
    in_valid = 0; out_ready = 1;
    step(); step(); step();

    // Reset with both stages full; out_ready high in the reset cycle
    out_ready = 0; in_valid = 1; in_data = 12'hABC;
    step();
    in_data = 12'hDEF;
    step();
    in_valid = 0;
    @(negedge clk);
    chk("full_before_rst", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    step();
    rst = 1; out_ready = 1;
    step();
    rst = 0;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_cnt_y3", cnt_y3, 0);
    step(); step(); step(); step();

    // Saturation with all-ones operands, then clear coincident with a transfer
    in_valid = 1; in_data = '1;
    for (int t = 0; t < 10; t++) step();
    in_valid = 0;
    step(); step(); step();
`ifdef CASE7_LANE_STATS_EN
    @(negedge clk);
    chk("sat_cnt_y2", cnt_y2, 15);
    chk("sat_cnt_y1", cnt_y1, 15);
`endif
    step();
    in_valid = 1; in_data = '1;
    step();
    in_valid = 0;
    step();
    stat_clr = 1;
    @(negedge clk);
    chk("clr_xfer_valid", out_valid, 1);
    step();
    stat_clr = 0;
    @(negedge clk);
    chk("clr_cnt_y2", cnt_y2, 0);
    chk("clr_cnt_y1", cnt_y1, 0);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
